// File: rtl/vector_memory_arbiter_if.sv
// Bundle of CPU, host loader/dumper and memory-port signals around the vector memory arbiter.
// The slave modport is the arbiter; the master modport is the environment (CPU, host, memory).
interface vector_memory_arbiter_if #(
  parameter int DATA_WIDTH    = 152,
  parameter int ADDRESS_WIDTH = 19,
  parameter int BURST_WIDTH   = 8
);
  logic                     cpuReq;
  logic                     cpuWrite;
  logic [ADDRESS_WIDTH-1:0] cpuAddress;
  logic [DATA_WIDTH-1:0]    cpuWriteData;
  logic                     cpuStall;
  logic [DATA_WIDTH-1:0]    cpuReadData;
  logic                     cpuReadValid;

  logic                     hostStart;
  logic                     hostWrite;
  logic [ADDRESS_WIDTH-1:0] hostBaseAddress;
  logic [BURST_WIDTH-1:0]   hostLength;
  logic                     hostBeatValid;
  logic [DATA_WIDTH-1:0]    hostWriteData;
  logic                     hostBeatReady;
  logic [DATA_WIDTH-1:0]    hostReadData;
  logic                     hostReadValid;
  logic                     hostBusy;
  logic                     hostDone;

  logic                     memWriteEnable;
  logic [ADDRESS_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0]    memWriteData;
  logic [DATA_WIDTH-1:0]    memReadData;

  modport slave (
    input  cpuReq, cpuWrite, cpuAddress, cpuWriteData,
    output cpuStall, cpuReadData, cpuReadValid,
    input  hostStart, hostWrite, hostBaseAddress, hostLength, hostBeatValid, hostWriteData,
    output hostBeatReady, hostReadData, hostReadValid, hostBusy, hostDone,
    output memWriteEnable, memAddress, memWriteData,
    input  memReadData
  );

  modport master (
    output cpuReq, cpuWrite, cpuAddress, cpuWriteData,
    input  cpuStall, cpuReadData, cpuReadValid,
    output hostStart, hostWrite, hostBaseAddress, hostLength, hostBeatValid, hostWriteData,
    input  hostBeatReady, hostReadData, hostReadValid, hostBusy, hostDone,
    input  memWriteEnable, memAddress, memWriteData,
    output memReadData
  );
endinterface

// File: rtl/vector_memory_arbiter.sv
// Shares the single-port vector memory between single-beat CPU accesses and host bursts,
// bounding CPU starvation to HOLD_LIMIT consecutive host beats.
module vector_memory_arbiter #(
  parameter int DATA_WIDTH    = 152,
  parameter int ADDRESS_WIDTH = 19,
  parameter int BURST_WIDTH   = 8,
  parameter int HOLD_LIMIT    = 4
) (
  input logic                  clock,
  input logic                  reset,
  vector_memory_arbiter_if.slave bus
);
  localparam int STARVE_WIDTH = $clog2(HOLD_LIMIT + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic                     host_write_q, host_write_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [BURST_WIDTH-1:0]   length_q, length_d;
  logic [BURST_WIDTH-1:0]   index_q, index_d;
  logic [STARVE_WIDTH-1:0]  starve_q, starve_d;

  logic                     cpu_read_valid_q;
  logic [DATA_WIDTH-1:0]    cpu_read_data_q;
  logic                     host_read_valid_q;
  logic [DATA_WIDTH-1:0]    host_read_data_q;
  logic                     host_done_q;

  logic                     cpu_grant;
  logic                     host_grant;
  logic                     beat_done;
  logic                     last_beat;
  logic [ADDRESS_WIDTH-1:0] host_address;

  // Grants are forced low while reset is held so the memory port is quiet immediately.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    cpu_grant  = 1'b0;
    host_grant = 1'b0;
    if (reset) begin
      if (state_q == IDLE) begin
        cpu_grant = bus.cpuReq;
      end else begin
        cpu_grant  = bus.cpuReq &&
                     ((starve_q == STARVE_WIDTH'(HOLD_LIMIT)) ||
                      (host_write_q && !bus.hostBeatValid));
        host_grant = !cpu_grant;
      end
    end
  end

  assign beat_done    = host_grant && (!host_write_q || bus.hostBeatValid);
  assign last_beat    = (index_q == length_q - BURST_WIDTH'(1));
  assign host_address = base_q + ADDRESS_WIDTH'(index_q);

  always_comb begin
    state_d      = state_q;
    host_write_d = host_write_q;
    base_d       = base_q;
    length_d     = length_q;
    index_d      = index_q;
    unique case (state_q)
      IDLE: begin
        if (bus.hostStart && (bus.hostLength != '0)) begin
          state_d      = BURST;
          host_write_d = bus.hostWrite;
          base_d       = bus.hostBaseAddress;
          length_d     = bus.hostLength;
          index_d      = '0;
        end
      end
      BURST: begin
        if (beat_done) begin
          if (last_beat) state_d = IDLE;
          else           index_d = index_q + BURST_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Starvation only accumulates while the CPU is actually waiting.
    if (cpu_grant || !bus.cpuReq) begin
      starve_d = '0;
    end else if (beat_done && (starve_q != STARVE_WIDTH'(HOLD_LIMIT))) begin
      starve_d = starve_q + STARVE_WIDTH'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      host_write_q      <= 1'b0;
      base_q            <= '0;
      length_q          <= '0;
      index_q           <= '0;
      starve_q          <= '0;
      cpu_read_valid_q  <= 1'b0;
      cpu_read_data_q   <= '0;
      host_read_valid_q <= 1'b0;
      host_read_data_q  <= '0;
      host_done_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q           <= state_d;
      host_write_q      <= host_write_d;
      base_q            <= base_d;
      length_q          <= length_d;
      index_q           <= index_d;
      starve_q          <= starve_d;
      cpu_read_valid_q  <= cpu_grant && !bus.cpuWrite;
      host_read_valid_q <= beat_done && !host_write_q;
      host_done_q       <= beat_done && last_beat;
      if (cpu_grant && !bus.cpuWrite) cpu_read_data_q  <= bus.memReadData;
      if (beat_done && !host_write_q) host_read_data_q <= bus.memReadData;
    end
  end

  // A host write beat only strobes memory once its data is actually present.
  assign bus.memWriteEnable = (cpu_grant && bus.cpuWrite) || (beat_done && host_write_q);
  assign bus.memAddress     = host_grant ? host_address      : bus.cpuAddress;
  assign bus.memWriteData   = host_grant ? bus.hostWriteData : bus.cpuWriteData;

  assign bus.cpuStall      = bus.cpuReq && !cpu_grant;
  assign bus.cpuReadData   = cpu_read_data_q;
  assign bus.cpuReadValid  = cpu_read_valid_q;
  assign bus.hostBeatReady = host_grant;
  assign bus.hostReadData  = host_read_data_q;
  assign bus.hostReadValid = host_read_valid_q;
  assign bus.hostBusy      = (state_q == BURST);
  assign bus.hostDone      = host_done_q;
endmodule

// File: tb/tb_vector_memory_arbiter.sv
// Directed self-checking bench for vector_memory_arbiter with a small behavioural memory.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_vector_memory_arbiter;
  localparam int DW = 152;
  localparam int AW = 19;
  localparam int BW = 8;

  logic clock;
  logic reset;
  int   check_count = 0;
  int   pass_count  = 0;

  vector_memory_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BURST_WIDTH(BW)) bus ();

  vector_memory_arbiter #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BURST_WIDTH(BW), .HOLD_LIMIT(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model aliased on the low 8 address bits; tests keep their addresses distinct.
  logic [DW-1:0] mem [0:255];
  assign bus.memReadData = mem[bus.memAddress[7:0]];
  always @(posedge clock) begin
    if (bus.memWriteEnable) mem[bus.memAddress[7:0]] <= bus.memWriteData;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    check_count++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             pass_count++;
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  initial begin
    logic [11:0] cpu_slots;
    logic [5:0]  valid_pat;
    int          rv_count;
    int          beat;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset               = 1'b0;
    bus.cpuReq          = 1'b1;
    bus.cpuWrite        = 1'b0;
    bus.cpuAddress      = '0;
    bus.cpuWriteData    = '0;
    bus.hostStart       = 1'b0;
    bus.hostWrite       = 1'b0;
    bus.hostBaseAddress = '0;
    bus.hostLength      = '0;
    bus.hostBeatValid   = 1'b0;
    bus.hostWriteData   = '0;

    // Reset state
    #2;
    check("rst_stall",   bus.cpuStall, 1);
    check("rst_we",      bus.memWriteEnable, 0);
    check("rst_ready",   bus.hostBeatReady, 0);
    check("rst_busy",    bus.hostBusy, 0);
    check("rst_done",    bus.hostDone, 0);
    check("rst_crv",     bus.cpuReadValid, 0);
    check("rst_hrv",     bus.hostReadValid, 0);
    check("rst_crd",     bus.cpuReadData, 0);
    bus.cpuReq = 1'b0;
    advance();
    advance();
    reset = 1'b1;

    // CPU write then read of address 5
    bus.cpuReq       = 1'b1;
    bus.cpuWrite     = 1'b1;
    bus.cpuAddress   = 19'd5;
    bus.cpuWriteData = 152'hABC;
    settle();
    check("cpu_wr_we",    bus.memWriteEnable, 1);
    check("cpu_wr_stall", bus.cpuStall, 0);
    check("cpu_wr_addr",  bus.memAddress, 5);
    check("cpu_wr_data",  bus.memWriteData, 152'hABC);
    advance();
    bus.cpuWrite = 1'b0;
    settle();
    check("cpu_rd_stall", bus.cpuStall, 0);
    check("cpu_rd_we",    bus.memWriteEnable, 0);
    advance();
    bus.cpuReq = 1'b0;
    settle();
    check("cpu_rd_valid", bus.cpuReadValid, 1);
    check("cpu_rd_data",  bus.cpuReadData, 152'hABC);
    advance();
    settle();
    check("cpu_rd_valid_drop", bus.cpuReadValid, 0);
    advance();

    // Host write burst base 0x10, length 3
    bus.hostStart       = 1'b1;
    bus.hostWrite       = 1'b1;
    bus.hostBaseAddress = 19'h10;
    bus.hostLength      = 8'd3;
    bus.hostBeatValid   = 1'b1;
    settle();
    check("hw_busy_start", bus.hostBusy, 0);
    advance();
    bus.hostStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.hostWriteData = DW'(32'h100 + i);
      settle();
      check($sformatf("hw_busy_%0d", i),  bus.hostBusy, 1);
      check($sformatf("hw_ready_%0d", i), bus.hostBeatReady, 1);
      check($sformatf("hw_we_%0d", i),    bus.memWriteEnable, 1);
      check($sformatf("hw_addr_%0d", i),  bus.memAddress, DW'(32'h10 + i));
      check($sformatf("hw_data_%0d", i),  bus.memWriteData, DW'(32'h100 + i));
      advance();
    end
    bus.hostBeatValid = 1'b0;
    settle();
    check("hw_done",     bus.hostDone, 1);
    check("hw_busy_end", bus.hostBusy, 0);
    advance();
    settle();
    check("hw_done_drop", bus.hostDone, 0);
    check("hw_mem_12",    mem[8'h12], 152'h102);
    advance();

    // Host read burst length 10 against a continuously requesting CPU
    bus.cpuReq          = 1'b1;
    bus.cpuWrite        = 1'b0;
    bus.cpuAddress      = 19'd5;
    bus.hostStart       = 1'b1;
    bus.hostWrite       = 1'b0;
    bus.hostBaseAddress = 19'h10;
    bus.hostLength      = 8'd10;
    settle();
    check("rb_start_stall", bus.cpuStall, 0);
    advance();
    bus.hostStart = 1'b0;
    cpu_slots = 12'h210;
    rv_count  = 0;
    for (int c = 0; c < 12; c++) begin
      settle();
      check($sformatf("rb_ready_%0d", c), bus.hostBeatReady, !cpu_slots[c]);
      check($sformatf("rb_stall_%0d", c), bus.cpuStall, !cpu_slots[c]);
      if (bus.hostReadValid) rv_count++;
      if (c == 1) check("rb_first_data", bus.hostReadData, 152'h100);
      if (c == 5) check("rb_cpu_valid",  bus.cpuReadValid, 1);
      advance();
    end
    bus.cpuReq = 1'b0;
    settle();
    if (bus.hostReadValid) rv_count++;
    check("rb_done", bus.hostDone, 1);
    advance();
    settle();
    if (bus.hostReadValid) rv_count++;
    check("rb_busy_end", bus.hostBusy, 0);
    check("rb_rv_count", DW'(rv_count), 10);
    advance();

    // Write burst length 4 with gaps in host data; CPU fills the gaps
    bus.cpuReq          = 1'b1;
    bus.cpuAddress      = 19'd5;
    bus.hostStart       = 1'b1;
    bus.hostWrite       = 1'b1;
    bus.hostBaseAddress = 19'h20;
    bus.hostLength      = 8'd4;
    bus.hostBeatValid   = 1'b0;
    advance();
    bus.hostStart = 1'b0;
    valid_pat = 6'b111001;
    beat      = 0;
    for (int c = 0; c < 6; c++) begin
      bus.hostBeatValid = valid_pat[c];
      bus.hostWriteData = DW'(32'h200 + beat);
      settle();
      check($sformatf("wg_stall_%0d", c), bus.cpuStall, valid_pat[c]);
      check($sformatf("wg_ready_%0d", c), bus.hostBeatReady, valid_pat[c]);
      check($sformatf("wg_we_%0d", c),    bus.memWriteEnable, valid_pat[c]);
      if (valid_pat[c]) begin
        check($sformatf("wg_addr_%0d", c), bus.memAddress, DW'(32'h20 + beat));
        beat++;
      end
      advance();
    end
    bus.hostBeatValid = 1'b0;
    bus.cpuReq        = 1'b0;
    settle();
    check("wg_done",   bus.hostDone, 1);
    check("wg_mem_21", mem[8'h21], 152'h201);
    check("wg_mem_23", mem[8'h23], 152'h203);
    advance();

    // Address wrap at the top of memory
    bus.hostStart       = 1'b1;
    bus.hostWrite       = 1'b1;
    bus.hostBaseAddress = 19'h7FFFF;
    bus.hostLength      = 8'd2;
    bus.hostBeatValid   = 1'b1;
    bus.hostWriteData   = 152'h300;
    advance();
    bus.hostStart = 1'b0;
    settle();
    check("wrap_addr0", bus.memAddress, 19'h7FFFF);
    check("wrap_we0",   bus.memWriteEnable, 1);
    advance();
    bus.hostWriteData = 152'h301;
    settle();
    check("wrap_addr1", bus.memAddress, 0);
    advance();
    bus.hostBeatValid = 1'b0;
    settle();
    check("wrap_done",  bus.hostDone, 1);
    check("wrap_mem_ff", mem[8'hFF], 152'h300);
    check("wrap_mem_00", mem[8'h00], 152'h301);
    advance();

    // Zero-length start is ignored
    bus.hostStart  = 1'b1;
    bus.hostLength = 8'd0;
    advance();
    bus.hostStart = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      check($sformatf("zero_busy_%0d", c), bus.hostBusy, 0);
      check($sformatf("zero_done_%0d", c), bus.hostDone, 0);
      advance();
    end

    // Reset during beat 3 of an 8-beat write burst
    bus.cpuAddress      = '0;
    bus.cpuWriteData    = '0;
    bus.hostStart       = 1'b1;
    bus.hostWrite       = 1'b1;
    bus.hostBaseAddress = 19'h40;
    bus.hostLength      = 8'd8;
    bus.hostBeatValid   = 1'b1;
    advance();
    bus.hostStart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.hostWriteData = DW'(32'h400 + i);
      settle();
      advance();
    end
    bus.hostWriteData = 152'h402;
    settle();
    check("mr_ready_beat3", bus.hostBeatReady, 1);
    #1;
    reset = 1'b0;
    #1;
    check("mr_busy",  bus.hostBusy, 0);
    check("mr_ready", bus.hostBeatReady, 0);
    check("mr_we",    bus.memWriteEnable, 0);
    check("mr_stall", bus.cpuStall, 0);
    check("mr_done",  bus.hostDone, 0);
    check("mr_addr",  bus.memAddress, 0);
    check("mr_crd",   bus.cpuReadData, 0);
    check("mr_hrd",   bus.hostReadData, 0);
    check("mr_hrv",   bus.hostReadValid, 0);
    advance();
    bus.hostBeatValid = 1'b0;
    #2;
    reset = 1'b1;
    settle();
    check("mr_post_done", bus.hostDone, 0);
    check("mr_post_busy", bus.hostBusy, 0);
    advance();

    // A fresh one-beat read burst is accepted after reset
    bus.hostStart       = 1'b1;
    bus.hostWrite       = 1'b0;
    bus.hostBaseAddress = 19'h10;
    bus.hostLength      = 8'd1;
    advance();
    bus.hostStart = 1'b0;
    settle();
    check("nr_busy",  bus.hostBusy, 1);
    check("nr_ready", bus.hostBeatReady, 1);
    advance();
    settle();
    check("nr_done",  bus.hostDone, 1);
    check("nr_hrv",   bus.hostReadValid, 1);
    check("nr_hrd",   bus.hostReadData, 152'h100);
    advance();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
